rib_rr_arbiter: RTL
===================

Name: rib_rr_arbiter

Overview:
- Round-robin bus arbiter for the four RIB masters: m0 core data, m1 pc fetch, m2 jtag, m3 uart_debug.
- Replaces fixed-priority master selection. The pc fetch request is tied permanently high, so with fixed priority the jtag and uart_debug masters can be starved; round-robin prevents this.
- Holds a grant across multi-cycle slaves until the slave returns ready (i2c today). Drives the core hold flag.
- Sits between the master request lines and the rib address/data mux. The mux is steered by grant_idx_o.

Parameters:
- NUM_M, 4, number of masters. Fixed at 4; grant_idx_o is 2 bits.
- TIMEOUT_CYC, 255, maximum number of cycles a grant waits for ready_i before a forced release. Only used with RIB_ARB_TIMEOUT_EN.
- TO_W, 8, width of the timeout counter. TIMEOUT_CYC must fit in TO_W bits.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous reset, active-high.
- req_i, input, 4: per-master request. Bit n is master n.
- ready_i, input, 1: ready from the slave currently addressed by the granted master.
- grant_o, output, 4: one-hot grant, registered.
- grant_idx_o, output, 2: index of the granted master, registered.
- grant_valid_o, output, 1: high while a grant is active.
- hold_flag_o, output, 1: core stall request. Combinational from registered state and req_i.
- timeout_o, output, 1: one-cycle pulse on a forced release.
- err_idx_o, output, 2: index of the master whose grant last timed out. Sticky until reset.

Behaviour:
- Reset values (sync, rst=1 sampled at posedge clk):
  - grant_o=0, grant_idx_o=0, grant_valid_o=0.
  - timeout_o=0, err_idx_o=0.
  - priority pointer ptr=0, state=IDLE, timeout counter=0.
- Reset mid-grant: grant is dropped at the next edge; no completion is recorded.
- Priority order: ptr, ptr+1, ptr+2, ptr+3, all mod 4. The first requesting master in this order wins.
- State IDLE:
  - If req_i != 0: register the winner into grant_o/grant_idx_o, set grant_valid_o=1, go to GRANT.
  - Grant is visible the cycle after the request is sampled (1-cycle latency).
  - If req_i == 0: stay in IDLE, all grant outputs 0.
- State GRANT, with g = grant_idx_o:
  - Completion: req_i[g]=1 and ready_i=1 in the same cycle. Set ptr=(g+1) mod 4, then re-arbitrate in that cycle using the new ptr.
    - If any req: the new grant takes effect next edge and the state stays GRANT. This gives back-to-back transfers with no idle cycle.
    - If no req: go to IDLE.
  - Abandon: req_i[g]=0, regardless of ready_i. Treated exactly as completion, ptr=(g+1) mod 4.
  - Otherwise (req_i[g]=1, ready_i=0): hold the grant unchanged. Requests from other masters are ignored until release.
- Simultaneous events:
  - A new request arriving in the completion cycle participates in that cycle's re-arbitration.
  - The just-completed master ranks lowest; it can win again only if it is the sole requester.
- hold_flag_o = (req_i[0] & ~(grant_valid_o & grant_o[0])) | (grant_valid_o & (grant_o[2] | grant_o[3])).
  - Asserted while the core data master waits for the bus, or while jtag or uart_debug owns it.
- grant_o is always one-hot or zero. grant_o is nonzero if and only if grant_valid_o=1.
- ptr changes only on completion or abandon.

Optional Feature:
- Macro RIB_ARB_TIMEOUT_EN.
- Defined:
  - TO_W-bit counter clears on every new grant and increments each GRANT cycle in which ready_i=0.
  - When the counter reaches TIMEOUT_CYC with no completion or abandon: forced release, treated as completion (ptr and re-arbitration apply).
  - In the same edge: timeout_o=1 for one cycle and err_idx_o=g.
  - A completion in that same cycle has priority; no timeout is flagged.
- Not defined: no counter; timeout_o and err_idx_o are tied to 0; the grant waits indefinitely for ready_i.

Test Plan:
- Reset: hold rst=1 for 3 cycles with req_i=4'b1111 -> all outputs 0 throughout. First grant is master 0, one cycle after rst falls.
- Single request: req_i=4'b1000, ready_i=1 -> grant_o=4'b1000 one cycle later, hold_flag_o=1. Drop req -> IDLE next cycle, grant_o=0.
- Fairness: req_i=4'b1111, ready_i=1 constantly -> grant_idx_o sequence 0,1,2,3,0,1 on consecutive cycles, grant_valid_o never drops.
- Stalled slave: grant m2, ready_i=0 for 3 cycles then 1, with req_i=4'b0111 -> grant_o=4'b0100 held 4 cycles, then m0 granted (ptr=3, next requester after wrap).
- Abandon: grant m1, deassert req_i[1] with ready_i=0 and req_i[3]=1 -> m3 granted next cycle, timeout_o=0.
- Timeout (macro on, TIMEOUT_CYC=4): grant m3, ready_i=0 held -> timeout_o pulses after 4 stall cycles, err_idx_o=3, next requester granted. Macro off: grant is held for 50 cycles with no timeout.

Source files
------------

// File: rtl/rib_rr_arbiter.sv
// rib_rr_arbiter: round-robin grant of the four RIB masters, held until slave ready; optional forced release via RIB_ARB_TIMEOUT_EN
module rib_rr_arbiter #(
  parameter int NUM_M       = 4,
  parameter int TIMEOUT_CYC = 255,
  parameter int TO_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NUM_M-1:0] req_i,
  input  logic             ready_i,
  output logic [NUM_M-1:0] grant_o,
  output logic [1:0]       grant_idx_o,
  output logic             grant_valid_o,
  output logic             hold_flag_o,
  output logic             timeout_o,
  output logic [1:0]       err_idx_o
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state;
  logic [1:0] ptr, base, win;
  logic any, done, force_rel, rel;
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC >= 2 ** TO_W) begin : g_bad_cfg
    $error("TIMEOUT_CYC must be in 1 .. 2**TO_W-1");
  end
  assign any  = |req_i;
  assign done = ~req_i[grant_idx_o] | ready_i;
  assign rel  = (state == GRANT) & (done | force_rel);
  // on release the just-served master ranks lowest
  assign base = rel ? grant_idx_o + 2'd1 : ptr;
  always_comb begin
    win = base;
    for (int k = 3; k >= 0; k--) win = req_i[base + 2'(k)] ? base + 2'(k) : win;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      ptr           <= '0;
      grant_o       <= '0;
      grant_idx_o   <= '0;
      grant_valid_o <= 1'b0;
    end else if (state == IDLE || rel) begin
      if (rel) ptr <= base;
      state         <= any ? GRANT : IDLE;
      grant_valid_o <= any;
      grant_idx_o   <= any ? win : 2'd0;
      grant_o       <= any ? NUM_M'(1) << win : '0;
    end
  end
  assign hold_flag_o = (req_i[0] & ~(grant_valid_o & grant_o[0])) |
                       (grant_valid_o & (grant_o[2] | grant_o[3]));
`ifdef RIB_ARB_TIMEOUT_EN
  logic [TO_W-1:0] cnt;
  assign force_rel = ~done & (cnt == TO_W'(TIMEOUT_CYC - 1));
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      timeout_o <= 1'b0;
      err_idx_o <= '0;
    end else begin
      cnt       <= (state == IDLE || rel) ? '0 : cnt + (ready_i ? TO_W'(0) : TO_W'(1));
      timeout_o <= (state == GRANT) & force_rel;
      err_idx_o <= (state == GRANT) & force_rel ? grant_idx_o : err_idx_o;
    end
  end
`else
  assign force_rel = 1'b0;
  assign timeout_o = 1'b0;
  assign err_idx_o = 2'd0;
`endif
endmodule
